// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down counter with one-shot/periodic modes and terminal-count pulse
module down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_next_reload;
    logic             r_tc;
    logic             w_next_tc;
    logic             w_count_zero;
    logic             w_count_one;

    assign w_count_zero = (r_count == '0);
    assign w_count_one  = (r_count == WIDTH'(1));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_next_count;
            r_reload <= w_next_reload;
            r_tc     <= w_next_tc;
        end
    end

    // tc is registered alongside the 1->0 step, so it is high while count reads 0
    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_reload = r_reload;
        w_next_tc     = 1'b0;
        if (stop) begin
            w_next_state = ST_IDLE;
        end else if (load) begin
            w_next_count  = load_val;
            w_next_reload = load_val;
            w_next_state  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (r_state == ST_RUN && en) begin
            if (!w_count_zero) begin
                w_next_count = r_count - WIDTH'(1);
                w_next_tc    = w_count_one;
            end else if (mode) begin
                w_next_count = r_reload;
            end else begin
                w_next_state = ST_DONE;
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - directed and randomized checks of down_counter against a reference model
module tb_down_counter;

    logic       clk = 1'b0;
    logic       clear;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       mode;
    logic       stop;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int tc_seen = 0;

    // reference model: phase 0 idle, 1 running, 2 finished
    int m_count  = 0;
    int m_reload = 0;
    int m_phase  = 0;
    int m_tc     = 0;

    down_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .stop     (stop),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count  = 0;
        m_reload = 0;
        m_phase  = 0;
        m_tc     = 0;
    endtask

    task automatic model_step();
        m_tc = 0;
        if (stop) begin
            m_phase = 0;
        end else if (load) begin
            m_count  = int'(load_val);
            m_reload = int'(load_val);
            m_phase  = (load_val != 0) ? 1 : 0;
        end else if (m_phase == 1 && en) begin
            if (m_count > 0) begin
                m_count = m_count - 1;
                if (m_count == 0) m_tc = 1;
            end else if (mode) begin
                m_count = m_reload;
            end else begin
                m_phase = 2;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " count"}, 32'(count), 32'(m_count));
        check({tag, " tc"},    32'(tc),    32'(m_tc));
        check({tag, " busy"},  32'(busy),  32'(m_phase == 1));
        check({tag, " done"},  32'(done),  32'(m_phase == 2));
    endtask

    task automatic drive(input logic e, input logic l, input logic [3:0] lv,
                         input logic m, input logic s);
        en = e; load = l; load_val = lv; mode = m; stop = s;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        if (tc === 1'b1) tc_seen++;
        check_model(tag);
    endtask

    initial begin
        clear = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        check_model("reset");
        @(posedge clk);
        #1;
        check_model("reset_held");
        clear = 1'b0;

        // one-shot from 3
        drive(1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        tick("os_load");
        check("os_first", 32'(count), 32'd3);
        load = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 9; i++) tick("oneshot");
        check("os_tc_pulses", 32'(tc_seen), 32'd1);
        check("os_done_hold", 32'({done, count}), 32'h10);

        // periodic reload from 2
        drive(1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
        tick("per_load");
        load = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 8; i++) tick("periodic");
        check("per_tc_pulses", 32'(tc_seen), 32'd3);
        check("per_busy", 32'(busy), 32'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        tick("per_stop");

        // alternating enable
        drive(1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
        tick("gap_load");
        load = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 8; i++) begin
            en = (i % 2 == 0);
            tick("gap");
        end
        check("gap_tc_pulses", 32'(tc_seen), 32'd1);
        check("gap_end", 32'({busy, count}), 32'h10);

        // stop beats load, load beats en
        drive(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
        tick("pri_load");
        load = 1'b0;
        tick("pri_run");
        tick("pri_run");
        drive(1'b1, 1'b1, 4'd12, 1'b0, 1'b1);
        tick("pri_both");
        check("pri_stop_wins", 32'({busy, count}), 32'h05);
        drive(1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
        tick("pri_load_en");
        check("pri_load_wins", 32'(count), 32'd12);

        // asynchronous clear at count 5
        load = 1'b0;
        for (int i = 0; i < 7; i++) tick("clr_run");
        check("clr_pre", 32'(count), 32'd5);
        #3;
        clear = 1'b1;
        #1;
        model_reset();
        check("clr_async", 32'({tc, busy, done, count}), 32'd0);
        #2;
        clear = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 3; i++) tick("clr_after");
        check("clr_no_tc", 32'(tc_seen), 32'd0);
        drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        tick("zero_load");
        load = 1'b0;
        tick("zero_idle");
        check("zero_stays_idle", 32'({busy, done}), 32'd0);

        // full-scale count, no wrap
        drive(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        tick("bnd_load");
        load = 1'b0;
        tc_seen = 0;
        for (int i = 0; i < 21; i++) tick("boundary");
        check("bnd_tc_pulses", 32'(tc_seen), 32'd1);
        check("bnd_no_wrap", 32'({done, count}), 32'h10);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0),
                  4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                  ($urandom_range(15, 0) == 0));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
